dispense_arbiter: RTL and testbench
===================================

Name: dispense_arbiter

Overview:
- Shares one physical water valve among NUM_REQ paid-up coin stations, each a quarter-accumulator FSM that raises a request once $2 is credited.
- Grants the valve round-robin and holds it open for exactly POUR_CYCLES open cycles.
- Pauses while the tank is empty, then returns a one-cycle done pulse to the served station so it can clear its credit.
- Sits between the per-station credit FSMs and the valve driver.

Parameters:
- NUM_REQ, 4, number of coin stations (2..8).
- POUR_CYCLES, 16, valve-open cycles per dispense (>=1).
- GAP_CYCLES, 2, valve-closed settle cycles after each dispense (>=1).

Ports:
- clock  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-station dispense request; level, held by the station until its done pulse.
- tank_empty  input  1  1 = no water; blocks new grants and pauses an active pour.
- grant  output  NUM_REQ  one-hot owner of the valve; all zero when unowned.
- valve_open  output  1  valve drive.
- done  output  NUM_REQ  one-cycle pulse to the served station at end of pour.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-low, on resetN; clock is clock. Reset values:
  - state = IDLE, grant = 0, valve_open = 0, done = 0, busy = 0.
  - round-robin pointer ptr = 0, pour counter = 0.
- Reset mid-pour closes the valve immediately. No done pulse is issued; the station keeps its credit and re-requests.
- States: IDLE, POUR, DONE, GAP.
- IDLE:
  - If (req != 0) and tank_empty = 0 at a clock edge: select winner i, the first set bit of req searching ptr, ptr+1, ... mod NUM_REQ.
  - Next state POUR; grant[i] registered high; counter loaded with POUR_CYCLES-1; ptr <= (i+1) mod NUM_REQ.
  - Otherwise remain in IDLE.
  - Latency: req high at edge k gives grant and valve open from edge k+1.
- POUR:
  - grant held; valve_open = (state==POUR) & ~tank_empty, combinational, so an empty tank closes the valve in the same cycle.
  - On each edge with valve_open = 1: if counter == 0, go to DONE; else decrement.
  - Edges with tank_empty = 1 leave the counter unchanged, so exactly POUR_CYCLES valve-open cycles are delivered regardless of pauses.
  - req[i] dropping during POUR is ignored; a paid pour always completes.
- DONE:
  - Lasts exactly 1 cycle, with valve_open = 0, done[i] = 1 and grant[i] still 1.
  - Next state GAP; grant cleared at that edge.
- GAP:
  - GAP_CYCLES cycles with grant = 0, valve_open = 0, busy = 1; then IDLE.
  - Each station deasserts req by the cycle after its done pulse. A req still high on return to IDLE is treated as a new request.
- Continuous requests from several stations: served strictly in rotation. Period = POUR_CYCLES + 1 + GAP_CYCLES + 1 cycles.
- Simultaneous events:
  - A req arriving during POUR, DONE or GAP waits for IDLE.
  - tank_empty rising in the same cycle as a request in IDLE blocks the grant.
  - tank_empty high on the last counted cycle closes the valve and delays DONE until tank_empty falls.
- Invariants: grant is one-hot or zero; valve_open implies grant != 0; done is a subset of grant.

Optional Feature:
- Macro DISPENSE_COUNT_EN.
- Defined: adds output pour_count [15:0], total completed dispenses.
  - Increments on each DONE cycle; saturates at 16'hFFFF.
  - Reset to 0; unchanged by aborted pours (reset mid-pour).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single request: req = 4'b0100 from edge 0, tank_empty = 0 -> grant = 4'b0100 and valve_open high cycles 1..16, done[2] = 1 in cycle 17, busy low from cycle 20.
- Round-robin: req = 4'b1011 held continuously -> grants in order 0001, 0010, 1000, 0001, each valve window 16 cycles, grant rising edges 20 cycles apart.
- Tank pause: tank_empty = 1 for 5 cycles starting at the 6th valve-open cycle -> valve_open low for those 5 cycles, 16 open cycles in total, done delayed by 5 cycles.
- Blocked start: tank_empty = 1 while req = 4'b0001 -> grant stays 0 and busy stays 0; tank_empty falls -> grant next cycle.
- Reset mid-pour: resetN low during the 8th open cycle -> valve_open, grant and busy go 0 asynchronously, no done pulse, ptr = 0 after release.
- DISPENSE_COUNT_EN: 3 full pours then 1 reset-aborted pour -> pour_count = 3 before reset and 0 after; preloading via 65535 pours holds 16'hFFFF.

Source files
------------

// File: rtl/dispense_arbiter.sv
// Round-robin arbiter sharing one water valve among paid-up coin stations.
// Define DISPENSE_COUNT_EN to add the saturating pour_count output.
module dispense_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned POUR_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic               clock,
   input  logic               resetN,
   input  logic [NUM_REQ-1:0] req,
   input  logic               tank_empty,
   output logic [NUM_REQ-1:0] grant,
   output logic               valve_open,
   output logic [NUM_REQ-1:0] done,
   output logic               busy
`ifdef DISPENSE_COUNT_EN
   ,
   output logic [15:0]        pour_count
`endif
);

   localparam int unsigned PtrW   = $clog2(NUM_REQ);
   localparam int unsigned MaxCnt = (POUR_CYCLES > GAP_CYCLES) ? POUR_CYCLES : GAP_CYCLES;
   localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

   typedef enum logic [1:0] {StIdle, StPour, StDone, StGap} state_e;

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [PtrW-1:0]     ptr_q, ptr_d;

   logic                found;
   logic [PtrW-1:0]     win_idx;
   logic [PtrW-1:0]     probe;
   int unsigned         idx;

   // First requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      probe   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx   = (32'(ptr_q) + k) % NUM_REQ;
         probe = PtrW'(idx);
         if (!found && req[probe]) begin
            found   = 1'b1;
            win_idx = probe;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (found && !tank_empty) begin
               state_d = StPour;
               grant_d = NUM_REQ'(1) << win_idx;
               cnt_d   = CntW'(POUR_CYCLES - 1);
               ptr_d   = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + PtrW'(1);
            end
         end
         StPour: begin
            // Counter only advances on cycles the valve was actually open.
            if (!tank_empty) begin
               if (cnt_q == '0) state_d = StDone;
               else             cnt_d   = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            state_d = StGap;
            grant_d = '0;
            cnt_d   = CntW'(GAP_CYCLES - 1);
         end
         StGap: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= StIdle;
         grant_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant      = grant_q;
   assign valve_open = (state_q == StPour) && !tank_empty;
   assign done       = (state_q == StDone) ? grant_q : '0;
   assign busy       = (state_q != StIdle);

`ifdef DISPENSE_COUNT_EN
   logic [15:0] count_q;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         count_q <= '0;
      end else if (state_q == StDone && count_q != 16'hFFFF) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign pour_count = count_q;
`endif

endmodule

// File: tb/tb_dispense_arbiter.sv
// Directed and randomized bench for dispense_arbiter against a dispense-level reference model.
module tb_dispense_arbiter;

   localparam int N    = 4;
   localparam int POUR = 16;
   localparam int GAP  = 2;

   logic         clock = 1'b0;
   logic         resetN = 1'b0;
   logic [N-1:0] req = '0;
   logic         tank_empty = 1'b0;
   logic [N-1:0] grant;
   logic         valve_open;
   logic [N-1:0] done;
   logic         busy;
`ifdef DISPENSE_COUNT_EN
   logic [15:0]  pour_count;
`endif

   dispense_arbiter #(
      .NUM_REQ(N),
      .POUR_CYCLES(POUR),
      .GAP_CYCLES(GAP)
   ) dut (
      .clock(clock),
      .resetN(resetN),
      .req(req),
      .tank_empty(tank_empty),
      .grant(grant),
      .valve_open(valve_open),
      .done(done),
      .busy(busy)
`ifdef DISPENSE_COUNT_EN
      ,
      .pour_count(pour_count)
`endif
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the valve, how many open cycles are still owed,
   // whether the done pulse is due, and how many settle cycles remain.
   int           m_owner = -1;
   int           m_owed  = 0;
   bit           m_done  = 1'b0;
   int           m_gap   = 0;
   int           m_ptr   = 0;
   int           m_count = 0;
   logic [N-1:0] last_exp_done = '0;
   int           open_seen = 0;

   function automatic logic [N-1:0] onehot(input int o);
      logic [N-1:0] v;
      v = '0;
      if (o >= 0) v = 4'b0001 << o;
      return v;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_owed  = 0;
      m_done  = 1'b0;
      m_gap   = 0;
      m_ptr   = 0;
      m_count = 0;
   endtask

   task automatic model_step();
      if (m_done) begin
         m_done  = 1'b0;
         m_owner = -1;
         m_gap   = GAP;
         if (m_count < 65535) m_count++;
      end else if (m_owner >= 0) begin
         if (!tank_empty) begin
            m_owed--;
            if (m_owed == 0) m_done = 1'b1;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (req != '0 && !tank_empty) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req[i]) begin
               m_owner = i;
               m_owed  = POUR;
               m_ptr   = (i + 1) % N;
               break;
            end
         end
      end
   endtask

   task automatic check(input string tag);
      logic [N-1:0] eg, ed;
      logic         ev, eb;
      eg = onehot(m_owner);
      ev = (m_owner >= 0) && (m_owed > 0) && !tank_empty;
      ed = m_done ? onehot(m_owner) : '0;
      eb = (m_owner >= 0) || (m_gap > 0);
      last_exp_done = ed;
      if (valve_open === 1'b1) open_seen++;
      total++;
      assert (grant === eg) else begin
         bad++;
         $error("FAIL %s grant got=%b want=%b", tag, grant, eg);
      end
      total++;
      assert (valve_open === ev) else begin
         bad++;
         $error("FAIL %s valve_open got=%b want=%b", tag, valve_open, ev);
      end
      total++;
      assert (done === ed) else begin
         bad++;
         $error("FAIL %s done got=%b want=%b", tag, done, ed);
      end
      total++;
      assert (busy === eb) else begin
         bad++;
         $error("FAIL %s busy got=%b want=%b", tag, busy, eb);
      end
`ifdef DISPENSE_COUNT_EN
      total++;
      assert (pour_count === 16'(m_count)) else begin
         bad++;
         $error("FAIL %s pour_count got=%0d want=%0d", tag, pour_count, m_count);
      end
`endif
   endtask

   // Apply inputs, check mid-cycle, then advance the model on the edge.
   task automatic tick(input logic [N-1:0] r, input logic te, input string tag);
      req        = r;
      tank_empty = te;
      #2;
      check(tag);
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic reset_pulse();
      resetN = 1'b0;
      model_reset();
      #1;
      check("async_reset");
      @(posedge clock);
      #1;
      resetN = 1'b1;
   endtask

   initial begin
      logic [N-1:0] st_req;
      logic         st_te;

      #1;
      check("reset_state");
      @(posedge clock);
      #1;
      resetN = 1'b1;

      // Single request from station 2.
      for (int c = 0; c < 18; c++) tick(4'b0100, 1'b0, "single");
      for (int c = 0; c < 5; c++)  tick(4'b0000, 1'b0, "single_tail");

      // Continuous requests rotate 0, 1, 3, 0...
      for (int c = 0; c < 80; c++) tick(4'b1011, 1'b0, "round_robin");
      for (int c = 0; c < 25; c++) tick(4'b0000, 1'b0, "rr_drain");

      // Tank empties for 5 cycles from the 6th open cycle.
      open_seen = 0;
      tick(4'b0001, 1'b0, "pause_start");
      for (int c = 0; c < 5; c++)  tick(4'b0001, 1'b0, "pause_pre");
      for (int c = 0; c < 5; c++)  tick(4'b0001, 1'b1, "pause_empty");
      for (int c = 0; c < 12; c++) tick(4'b0001, 1'b0, "pause_post");
      for (int c = 0; c < 25; c++) tick(4'b0000, 1'b0, "pause_drain");
      total++;
      assert (open_seen == POUR) else begin
         bad++;
         $error("FAIL pause_open_cycles got=%0d want=%0d", open_seen, POUR);
      end

      // Empty tank blocks the grant entirely, then releases it.
      for (int c = 0; c < 5; c++)  tick(4'b0001, 1'b1, "blocked");
      for (int c = 0; c < 18; c++) tick(4'b0001, 1'b0, "unblocked");
      for (int c = 0; c < 25; c++) tick(4'b0000, 1'b0, "blocked_drain");

      // Reset during the 8th open cycle; pointer restarts at station 0.
      tick(4'b0010, 1'b0, "rst_start");
      for (int c = 0; c < 7; c++) tick(4'b0010, 1'b0, "rst_pour");
      reset_pulse();
      for (int c = 0; c < 22; c++) tick(4'b1111, 1'b0, "post_reset");
      for (int c = 0; c < 25; c++) tick(4'b0000, 1'b0, "post_drain");

      // Stations raise at random and drop only after their done pulse.
      st_req = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (st_req[i] && last_exp_done[i]) st_req[i] = 1'b0;
            else if (!st_req[i] && $urandom_range(0, 7) == 0) st_req[i] = 1'b1;
         end
         st_te = ($urandom_range(0, 9) == 0);
         tick(st_req, st_te, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
